// File: rtl/reg_arb_pkg.sv
// Shared types for the register-set access arbiter: FSM encoding, requester
// indices and the pending-request record held by each requester slot.
package reg_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b01,
    S_WAIT = 2'b10
  } arb_state_e;

  localparam int REQ_APB = 0;
  localparam int REQ_CFG = 1;
  localparam int NUM_REQ = 2;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       is_write;
  } reg_req_t;

  // Round-robin pick between two pending requesters: a tie goes to the one
  // that was not granted last; otherwise the only pending one wins.
  function automatic logic rr_pick(input logic [NUM_REQ-1:0] pend, input logic last);
    if (pend[REQ_APB] && pend[REQ_CFG]) begin
      return ~last;
    end
    return pend[REQ_CFG];
  endfunction

endpackage

// File: rtl/reg_access_arbiter_if.sv
// Bundle of the two requester ports, the shared register-set port and the
// arbiter status outputs. The arbiter uses the slave view.
interface reg_access_arbiter_if;
  logic [7:0] r0_addr_i;
  logic [7:0] r0_wdata_i;
  logic       r0_wr_en_i;
  logic       r0_rd_en_i;
  logic [7:0] r0_rdata_o;
  logic       r0_wr_done_o;
  logic       r0_rd_done_o;
  logic       r0_err_o;

  logic [7:0] r1_addr_i;
  logic [7:0] r1_wdata_i;
  logic       r1_wr_en_i;
  logic       r1_rd_en_i;
  logic [7:0] r1_rdata_o;
  logic       r1_wr_done_o;
  logic       r1_rd_done_o;
  logic       r1_err_o;

  logic [7:0] reg_addr_o;
  logic [7:0] reg_data_o;
  logic [7:0] reg_data_i;
  logic       reg_wr_en_o;
  logic       reg_rd_en_o;
  logic       reg_wr_done_i;
  logic       reg_rd_done_i;

  logic [1:0] grant_o;
  logic       timeout_o;

  modport slave (
    input  r0_addr_i, r0_wdata_i, r0_wr_en_i, r0_rd_en_i,
    output r0_rdata_o, r0_wr_done_o, r0_rd_done_o, r0_err_o,
    input  r1_addr_i, r1_wdata_i, r1_wr_en_i, r1_rd_en_i,
    output r1_rdata_o, r1_wr_done_o, r1_rd_done_o, r1_err_o,
    output reg_addr_o, reg_data_o, reg_wr_en_o, reg_rd_en_o,
    input  reg_data_i, reg_wr_done_i, reg_rd_done_i,
    output grant_o, timeout_o
  );

  modport master (
    output r0_addr_i, r0_wdata_i, r0_wr_en_i, r0_rd_en_i,
    input  r0_rdata_o, r0_wr_done_o, r0_rd_done_o, r0_err_o,
    output r1_addr_i, r1_wdata_i, r1_wr_en_i, r1_rd_en_i,
    input  r1_rdata_o, r1_wr_done_o, r1_rd_done_o, r1_err_o,
    input  reg_addr_o, reg_data_o, reg_wr_en_o, reg_rd_en_o,
    output reg_data_i, reg_wr_done_i, reg_rd_done_i,
    input  grant_o, timeout_o
  );
endinterface

// File: rtl/reg_req_slot.sv
// One requester's pending-request latch and its registered response outputs
// (rdata, done pulses, err). The arbiter clears the latch on completion.
module reg_req_slot
  import reg_arb_pkg::*;
(
  input  logic       pclk_i,
  input  logic       preset_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] wdata_i,
  input  logic       wr_en_i,
  input  logic       rd_en_i,
  input  logic       clear_i,
  input  logic       err_i,
  input  logic [7:0] rdata_i,
  output logic       pend_o,
  output reg_req_t   req_o,
  output logic [7:0] rdata_o,
  output logic       wr_done_o,
  output logic       rd_done_o,
  output logic       err_o
);

  logic     valid_q;
  reg_req_t req_q;
  reg_req_t in_req;
  logic     accept;

  always_comb begin
    in_req          = '0;
    in_req.addr     = addr_i;
    in_req.wdata    = wr_en_i ? wdata_i : 8'h00;
    in_req.is_write = wr_en_i;
  end

  assign accept = !valid_q && (wr_en_i || rd_en_i);

  // An idle arbiter may grant on the same edge the request is latched, so the
  // incoming request is offered straight through while the latch is empty.
  assign pend_o = valid_q || wr_en_i || rd_en_i;
  assign req_o  = valid_q ? req_q : in_req;

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      valid_q   <= 1'b0;
      req_q     <= '0;
      rdata_o   <= 8'h00;
      wr_done_o <= 1'b0;
      rd_done_o <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      wr_done_o <= clear_i && req_q.is_write;
      rd_done_o <= clear_i && !req_q.is_write;
      err_o     <= clear_i && err_i;
      if (clear_i && !req_q.is_write && !err_i) begin
        rdata_o <= rdata_i;
      end
      if (clear_i) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        req_q   <= in_req;
      end
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter sharing the UART register-set port between the APB
// requester and the configuration sequencer, one access in flight at a time.
//
//   state  | meaning
//   S_IDLE | no access in flight; grant a pending request if any
//   S_WAIT | access issued; wait for matching done or the done-timeout
module reg_access_arbiter
  import reg_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic pclk_i,
  input logic preset_i,
  reg_access_arbiter_if.slave bus
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT_CYCLES - 1);

  arb_state_e state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic          is_wr_q, is_wr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          wr_en_q, wr_en_d;
  logic          rd_en_q, rd_en_d;
  logic [1:0]    grant_q, grant_d;
  logic          timeout_q, timeout_d;

  logic [NUM_REQ-1:0] pend;
  logic [NUM_REQ-1:0] cmpl;
  logic               cmpl_err;
  reg_req_t           req_apb, req_cfg, pick;
  logic               sel;
  logic               done_hit;

  reg_req_slot u_slot_apb (
    .pclk_i    (pclk_i),
    .preset_i  (preset_i),
    .addr_i    (bus.r0_addr_i),
    .wdata_i   (bus.r0_wdata_i),
    .wr_en_i   (bus.r0_wr_en_i),
    .rd_en_i   (bus.r0_rd_en_i),
    .clear_i   (cmpl[REQ_APB]),
    .err_i     (cmpl_err),
    .rdata_i   (bus.reg_data_i),
    .pend_o    (pend[REQ_APB]),
    .req_o     (req_apb),
    .rdata_o   (bus.r0_rdata_o),
    .wr_done_o (bus.r0_wr_done_o),
    .rd_done_o (bus.r0_rd_done_o),
    .err_o     (bus.r0_err_o)
  );

  reg_req_slot u_slot_cfg (
    .pclk_i    (pclk_i),
    .preset_i  (preset_i),
    .addr_i    (bus.r1_addr_i),
    .wdata_i   (bus.r1_wdata_i),
    .wr_en_i   (bus.r1_wr_en_i),
    .rd_en_i   (bus.r1_rd_en_i),
    .clear_i   (cmpl[REQ_CFG]),
    .err_i     (cmpl_err),
    .rdata_i   (bus.reg_data_i),
    .pend_o    (pend[REQ_CFG]),
    .req_o     (req_cfg),
    .rdata_o   (bus.r1_rdata_o),
    .wr_done_o (bus.r1_wr_done_o),
    .rd_done_o (bus.r1_rd_done_o),
    .err_o     (bus.r1_err_o)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    is_wr_d   = is_wr_q;
    timer_d   = timer_q;
    addr_d    = addr_q;
    data_d    = data_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;
    grant_d   = grant_q;
    timeout_d = 1'b0;
    cmpl      = '0;
    cmpl_err  = 1'b0;
    sel       = rr_pick(pend, last_q);
    pick      = sel ? req_cfg : req_apb;
    done_hit  = is_wr_q ? bus.reg_wr_done_i : bus.reg_rd_done_i;

    unique case (state_q)
      S_IDLE: begin
        if (|pend) begin
          addr_d  = pick.addr;
          data_d  = pick.wdata;
          wr_en_d = pick.is_write;
          rd_en_d = !pick.is_write;
          is_wr_d = pick.is_write;
          owner_d = sel;
          last_d  = sel;
          timer_d = '0;
          grant_d = sel ? 2'b10 : 2'b01;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // The enable cycle is not counted: the budget runs over the cycles
        // after the register set has seen the request.
        if (!(wr_en_q || rd_en_q)) begin
          timer_d = timer_q + 1'b1;
        end
        if (done_hit || timer_q == TC_LAST) begin
          cmpl[owner_q] = 1'b1;
          cmpl_err      = !done_hit;
          timeout_d     = !done_hit;
          grant_d       = 2'b00;
          state_d       = S_IDLE;
        end
      end
      default: begin
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      is_wr_q   <= 1'b0;
      timer_q   <= '0;
      addr_q    <= 8'h00;
      data_q    <= 8'h00;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      grant_q   <= 2'b00;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      is_wr_q   <= is_wr_d;
      timer_q   <= timer_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.reg_addr_o  = addr_q;
  assign bus.reg_data_o  = data_q;
  assign bus.reg_wr_en_o = wr_en_q;
  assign bus.reg_rd_en_o = rd_en_q;
  assign bus.grant_o     = grant_q;
  assign bus.timeout_o   = timeout_q;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Bench for reg_access_arbiter: a transaction-level reference model checked
// against every output each cycle, plus literal expectations per scenario.
module tb_reg_access_arbiter;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  reg_access_arbiter_if bus ();

  reg_access_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .pclk_i  (clk),
    .preset_i(rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0] in_wr, in_rd;
  logic [7:0] in_a [2];
  logic [7:0] in_d [2];
  assign in_wr   = {bus.r1_wr_en_i, bus.r0_wr_en_i};
  assign in_rd   = {bus.r1_rd_en_i, bus.r0_rd_en_i};
  assign in_a[0] = bus.r0_addr_i;
  assign in_a[1] = bus.r1_addr_i;
  assign in_d[0] = bus.r0_wdata_i;
  assign in_d[1] = bus.r1_wdata_i;

  bit         m_on = 1'b0;
  int         cyc = 0;
  bit         busy;
  int         cur, start, last, m_pick;
  bit         m_hit;
  bit         lat_v [2];
  bit         lat_w [2];
  logic [7:0] lat_a [2];
  logic [7:0] lat_d [2];
  logic [7:0] e_addr, e_data;
  logic [7:0] e_rdata [2];
  logic [1:0] e_grant;
  bit         e_wr_en, e_rd_en, e_to;
  bit         e_wd [2];
  bit         e_rd [2];
  bit         e_err [2];

  // At each edge: predict the outputs of the following cycle from the inputs
  // of the cycle that just ended.
  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1; busy = 1'b0; last = 1;
      e_grant = 2'b00; e_wr_en = 1'b0; e_rd_en = 1'b0; e_to = 1'b0;
      e_addr = 8'h00; e_data = 8'h00;
      for (int i = 0; i < 2; i++) begin
        lat_v[i] = 1'b0; e_rdata[i] = 8'h00; e_wd[i] = 1'b0; e_rd[i] = 1'b0; e_err[i] = 1'b0;
      end
    end else begin
      e_wr_en = 1'b0; e_rd_en = 1'b0; e_to = 1'b0;
      for (int i = 0; i < 2; i++) begin
        e_wd[i] = 1'b0; e_rd[i] = 1'b0; e_err[i] = 1'b0;
        if (!lat_v[i] && (in_wr[i] || in_rd[i])) begin
          lat_v[i] = 1'b1;
          lat_w[i] = in_wr[i];
          lat_a[i] = in_a[i];
          lat_d[i] = in_wr[i] ? in_d[i] : 8'h00;
        end
      end
      if (busy) begin
        m_hit = lat_w[cur] ? bus.reg_wr_done_i : bus.reg_rd_done_i;
        if (m_hit || cyc == start + TO) begin
          if (lat_w[cur]) e_wd[cur] = 1'b1; else e_rd[cur] = 1'b1;
          e_err[cur] = !m_hit;
          e_to       = !m_hit;
          if (m_hit && !lat_w[cur]) e_rdata[cur] = bus.reg_data_i;
          lat_v[cur] = 1'b0;
          busy       = 1'b0;
          e_grant    = 2'b00;
        end
      end else if (lat_v[0] || lat_v[1]) begin
        if (lat_v[0] && lat_v[1]) m_pick = 1 - last;
        else m_pick = lat_v[1] ? 1 : 0;
        last    = m_pick;
        cur     = m_pick;
        busy    = 1'b1;
        start   = cyc + 1;
        e_wr_en = lat_w[m_pick];
        e_rd_en = !lat_w[m_pick];
        e_addr  = lat_a[m_pick];
        e_data  = lat_d[m_pick];
        e_grant = (m_pick == 1) ? 2'b10 : 2'b01;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("grant_o", bus.grant_o, e_grant);
      chk("timeout_o", bus.timeout_o, e_to);
      chk("reg_wr_en_o", bus.reg_wr_en_o, e_wr_en);
      chk("reg_rd_en_o", bus.reg_rd_en_o, e_rd_en);
      chk("reg_addr_o", bus.reg_addr_o, e_addr);
      chk("reg_data_o", bus.reg_data_o, e_data);
      chk("r0_rdata_o", bus.r0_rdata_o, e_rdata[0]);
      chk("r1_rdata_o", bus.r1_rdata_o, e_rdata[1]);
      chk("r0_wr_done_o", bus.r0_wr_done_o, e_wd[0]);
      chk("r1_wr_done_o", bus.r1_wr_done_o, e_wd[1]);
      chk("r0_rd_done_o", bus.r0_rd_done_o, e_rd[0]);
      chk("r1_rd_done_o", bus.r1_rd_done_o, e_rd[1]);
      chk("r0_err_o", bus.r0_err_o, e_err[0]);
      chk("r1_err_o", bus.r1_err_o, e_err[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit wr, input bit rd,
                         input logic [7:0] a, input logic [7:0] d);
    if (i == 0) begin
      bus.r0_wr_en_i = wr; bus.r0_rd_en_i = rd; bus.r0_addr_i = a; bus.r0_wdata_i = d;
    end else begin
      bus.r1_wr_en_i = wr; bus.r1_rd_en_i = rd; bus.r1_addr_i = a; bus.r1_wdata_i = d;
    end
  endtask

  task automatic clr_req();
    bus.r0_wr_en_i = 1'b0; bus.r0_rd_en_i = 1'b0;
    bus.r1_wr_en_i = 1'b0; bus.r1_rd_en_i = 1'b0;
  endtask

  task automatic pulse(input int i, input bit wr, input bit rd,
                       input logic [7:0] a, input logic [7:0] d);
    set_req(i, wr, rd, a, d);
    tick();
    clr_req();
  endtask

  task automatic wait_enable(input string name);
    int k = 0;
    while (!(bus.reg_wr_en_o || bus.reg_rd_en_o) && k < 40) begin
      tick();
      k++;
    end
    chk(name, bus.reg_wr_en_o | bus.reg_rd_en_o, 1);
  endtask

  // Called in the enable cycle; returns in the cycle after done is sampled.
  task automatic serve(input bit wr, input logic [7:0] rd, input int delay);
    repeat (delay) tick();
    if (wr) bus.reg_wr_done_i = 1'b1; else bus.reg_rd_done_i = 1'b1;
    bus.reg_data_i = rd;
    tick();
    bus.reg_wr_done_i = 1'b0;
    bus.reg_rd_done_i = 1'b0;
  endtask

  initial begin
    int k;
    int n_en;
    clr_req();
    set_req(0, 0, 0, 8'h00, 8'h00);
    set_req(1, 0, 0, 8'h00, 8'h00);
    bus.reg_data_i = 8'h00; bus.reg_wr_done_i = 1'b0; bus.reg_rd_done_i = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_grant", bus.grant_o, 2'b00);
    chk("rst_rdata0", bus.r0_rdata_o, 8'h00);
    chk("rst_addr", bus.reg_addr_o, 8'h00);
    tick();

    // single write
    pulse(0, 1, 0, 8'h03, 8'hA5);
    chk("t1_wr_en", bus.reg_wr_en_o, 1);
    chk("t1_addr", bus.reg_addr_o, 8'h03);
    chk("t1_data", bus.reg_data_o, 8'hA5);
    chk("t1_grant", bus.grant_o, 2'b01);
    tick();
    chk("t1_en_one_cycle", bus.reg_wr_en_o, 0);
    serve(1, 8'h00, 0);
    chk("t1_done", bus.r0_wr_done_o, 1);
    chk("t1_err", bus.r0_err_o, 0);
    chk("t1_idle_grant", bus.grant_o, 2'b00);
    tick();
    chk("t1_done_one_cycle", bus.r0_wr_done_o, 0);

    // read from the sequencer
    pulse(1, 0, 1, 8'h05, 8'h00);
    chk("t2_rd_en", bus.reg_rd_en_o, 1);
    chk("t2_addr", bus.reg_addr_o, 8'h05);
    chk("t2_grant", bus.grant_o, 2'b10);
    serve(0, 8'h3C, 1);
    chk("t2_rdata", bus.r1_rdata_o, 8'h3C);
    chk("t2_done", bus.r1_rd_done_o, 1);
    chk("t2_r0_quiet", {bus.r0_wr_done_o, bus.r0_rd_done_o, bus.r0_err_o}, 3'b000);
    tick();

    // tie with pointer at 1: r0 first, then r1 after one idle cycle
    set_req(0, 0, 1, 8'h10, 8'h00);
    set_req(1, 1, 0, 8'h20, 8'h77);
    tick();
    clr_req();
    chk("t3_first_grant", bus.grant_o, 2'b01);
    chk("t3_first_addr", bus.reg_addr_o, 8'h10);
    serve(0, 8'h5A, 1);
    chk("t3_r0_rdata", bus.r0_rdata_o, 8'h5A);
    chk("t3_gap", {bus.grant_o, bus.reg_wr_en_o, bus.reg_rd_en_o}, 4'b0000);
    tick();
    chk("t3_second_grant", bus.grant_o, 2'b10);
    chk("t3_second_wr_en", bus.reg_wr_en_o, 1);
    chk("t3_second_addr", bus.reg_addr_o, 8'h20);
    chk("t3_second_data", bus.reg_data_o, 8'h77);
    serve(1, 8'h00, 2);
    tick();

    // lone r0 access moves the pointer to 0, so the next tie goes to r1
    pulse(0, 1, 0, 8'h12, 8'h34);
    wait_enable("t3_lone_enable");
    serve(1, 8'h00, 1);
    tick();
    set_req(0, 1, 0, 8'h13, 8'h01);
    set_req(1, 0, 1, 8'h21, 8'h00);
    tick();
    clr_req();
    chk("t3_tie2_first", bus.grant_o, 2'b10);
    chk("t3_tie2_addr", bus.reg_addr_o, 8'h21);
    serve(0, 8'h99, 1);
    tick();
    chk("t3_tie2_second", bus.grant_o, 2'b01);
    chk("t3_tie2_addr2", bus.reg_addr_o, 8'h13);
    serve(1, 8'h00, 1);
    chk("t3_tie2_done", bus.r0_wr_done_o, 1);
    tick();

    // timeout, with a stray non-matching done in between
    pulse(0, 0, 1, 8'h07, 8'h00);
    chk("t4_rd_en", bus.reg_rd_en_o, 1);
    k = 0;
    while (bus.r0_rd_done_o !== 1'b1 && k < 60) begin
      bus.reg_wr_done_i = (k == 3);
      tick();
      k++;
    end
    bus.reg_wr_done_i = 1'b0;
    chk("t4_latency", k, TO + 1);
    chk("t4_err", bus.r0_err_o, 1);
    chk("t4_timeout", bus.timeout_o, 1);
    chk("t4_rdata_kept", bus.r0_rdata_o, 8'h5A);
    tick();

    // done on the last allowed cycle wins over the timeout
    pulse(0, 0, 1, 8'h08, 8'h00);
    repeat (TO) tick();
    bus.reg_rd_done_i = 1'b1;
    bus.reg_data_i = 8'hC3;
    tick();
    bus.reg_rd_done_i = 1'b0;
    chk("t4b_done", bus.r0_rd_done_o, 1);
    chk("t4b_err", bus.r0_err_o, 0);
    chk("t4b_timeout", bus.timeout_o, 0);
    chk("t4b_rdata", bus.r0_rdata_o, 8'hC3);
    tick();

    // reset in the middle of an access; late done must be ignored
    pulse(1, 1, 0, 8'h30, 8'h44);
    chk("t5_wr_en", bus.reg_wr_en_o, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_grant", bus.grant_o, 2'b00);
    chk("t5_rdata_rst", bus.r1_rdata_o, 8'h00);
    bus.reg_wr_done_i = 1'b1;
    tick();
    bus.reg_wr_done_i = 1'b0;
    chk("t5_no_done", bus.r1_wr_done_o, 0);
    chk("t5_idle", bus.grant_o, 2'b00);
    pulse(1, 0, 1, 8'h31, 8'h00);
    chk("t5_new_rd_en", bus.reg_rd_en_o, 1);
    chk("t5_new_addr", bus.reg_addr_o, 8'h31);
    serve(0, 8'hE7, 1);
    chk("t5_new_rdata", bus.r1_rdata_o, 8'hE7);
    tick();

    // write beats read; r0 latched during r1's access; r0 duplicate dropped
    pulse(1, 1, 1, 8'h50, 8'h66);
    chk("t6_wr_prec", {bus.reg_wr_en_o, bus.reg_rd_en_o}, 2'b10);
    chk("t6_addr", bus.reg_addr_o, 8'h50);
    pulse(0, 1, 0, 8'h40, 8'h01);
    pulse(0, 1, 0, 8'h41, 8'h02);
    serve(1, 8'h00, 0);
    chk("t6_r1_done", bus.r1_wr_done_o, 1);
    tick();
    chk("t6_r0_grant", bus.grant_o, 2'b01);
    chk("t6_r0_addr", bus.reg_addr_o, 8'h40);
    chk("t6_r0_data", bus.reg_data_o, 8'h01);
    serve(1, 8'h00, 1);
    n_en = 0;
    repeat (6) begin
      tick();
      if (bus.reg_wr_en_o || bus.reg_rd_en_o) n_en++;
    end
    chk("t6_no_dup", n_en, 0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/reg_access_arbiter.md
# reg_access_arbiter

Two-requester arbiter and sequencer for the UART register-set access port. It shares the single register-set interface (address, write data, read data, write/read enable pulses, write/read done) between the APB interface (requester 0) and an internal configuration sequencer (requester 1). It serialises requests with round-robin fairness and enforces one outstanding register access at a time. A done-timeout guarantees every accepted request is answered.

## Interface
Parameters:
- TIMEOUT_CYCLES, 16: cycles in S_WAIT without a matching done before the access is aborted; legal range 2..255.

Ports (clock/reset first; `rN_` means one set each for N = 0, 1). One clock; reset is synchronous and active-high.
- pclk_i  in  1  reference clock; all logic on rising edge
- preset_i  in  1  synchronous active-high reset
- rN_addr_i  in  8  request address, sampled with an enable pulse
- rN_wdata_i  in  8  write data, sampled with rN_wr_en_i
- rN_wr_en_i  in  1  one-cycle write request pulse
- rN_rd_en_i  in  1  one-cycle read request pulse
- rN_rdata_o  out  8  read data, held until the next read completion for that requester
- rN_wr_done_o  out  1  one-cycle write completion pulse
- rN_rd_done_o  out  1  one-cycle read completion pulse
- rN_err_o  out  1  high with the done pulse when the access timed out
- reg_addr_o  out  8  register-set address
- reg_data_o  out  8  register-set write data
- reg_data_i  in  8  register-set read data
- reg_wr_en_o  out  1  register-set write enable pulse
- reg_rd_en_o  out  1  register-set read enable pulse
- reg_wr_done_i  in  1  register-set write done
- reg_rd_done_i  in  1  register-set read done
- grant_o  out  2  one-hot current owner; 2'b00 in S_IDLE
- timeout_o  out  1  one-cycle pulse on any abort

## Operation
- Pending latch per requester:
  - An enable pulse while that requester's latch is empty captures addr, wdata and direction, and sets the latch.
  - An enable while the requester's own latch is full is dropped silently.
  - wr_en and rd_en asserted together: write takes precedence.
- FSM states: S_IDLE, S_WAIT.
- S_IDLE: if any latch is pending, grant by round-robin.
  - The requester not granted last wins a tie.
  - The last-grant pointer resets to 1, so requester 0 wins the first tie.
  - On grant: register reg_addr_o/reg_data_o from the latch, pulse reg_wr_en_o or reg_rd_en_o, clear the timer, set grant_o, move to S_WAIT.
- S_WAIT:
  - Enable is deasserted after one cycle.
  - The timer increments each cycle.
  - Matching done (reg_wr_done_i for a write, reg_rd_done_i for a read):
    - Capture reg_data_i into rN_rdata_o (reads only).
    - Pulse the matching rN_*_done_o next cycle with err low.
    - Clear the latch, update the pointer, return to S_IDLE.
  - A non-matching done is ignored.
- Timeout: the timer equals TIMEOUT_CYCLES-1 with no matching done.
  - Pulse the matching done with rN_err_o=1 and pulse timeout_o.
  - rdata is unchanged.
  - Clear the latch and return to S_IDLE.
  - If done and timeout occur in the same cycle, done wins (err=0).
- Done inputs while in S_IDLE are ignored.
- A request arriving during another requester's S_WAIT is latched and served after completion.
- Reset values (reset valid at any time, including mid-access): all done/err/en/timeout outputs 0; rdata 8'h00; reg_addr_o/reg_data_o 8'h00; grant_o 2'b00; latches empty; FSM S_IDLE. No done is issued for an aborted in-flight access.

## Timing
- Request pulse in cycle T: latched at edge T.
  - Grant and reg enable are high in cycle T+1 (if idle).
  - The enable clears at edge T+2.
- Register-set done sampled at edge D: requester done is high in cycle D+1; FSM is S_IDLE in cycle D+1.
- Back-to-back: the next grant's enable is high in cycle D+2, so the minimum gap is one idle cycle.
- Timeout done is high TIMEOUT_CYCLES+1 cycles after the enable cycle.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package `reg_arb_pkg`: state enum (S_IDLE, S_WAIT; one-hot 2 bits), requester index constants REQ_APB=0 and REQ_CFG=1, and a request struct (addr, wdata, is_write).
- Sub-module `reg_req_slot`, instantiated twice: pending latch plus response registers (rdata, done, err), with a clear input from the arbiter FSM.
- Top level holds the FSM, round-robin pointer, timer (width $clog2(TIMEOUT_CYCLES)) and output muxing.

## Test plan
- Single write: r0 write addr 8'h03 data 8'hA5, done 1 cycle after enable → reg_wr_en_o one cycle with addr 03/data A5; r0_wr_done_o high in cycle D+1; err 0.
- Read: r1 read 8'h05, reg_data_i=8'h3C with done → r1_rdata_o=8'h3C, r1_rd_done_o one pulse; r0 outputs are quiet.
- Tie: r0 and r1 request in the same cycle, twice → order is r0, r1, then r1, r0; one idle cycle between accesses.
- Timeout: no done after a read enable → after TIMEOUT_CYCLES cycles, r0_rd_done_o=1, r0_err_o=1, timeout_o=1; rdata unchanged. A done landing on the final cycle → err 0.
- Reset asserted mid-S_WAIT, then done arrives after reset → no requester done; grant_o=00; latches empty; a new request is served normally.
- Duplicate: r0 issues a second request while pending → only one reg-set access occurs; the second is dropped.
